// File: rtl/alu_pkg.sv
// Shared arithmetic package.
// Holds the state encoding for the bit-serial adder sequencer. Operand width
// stays a module parameter of each user so this package remains width-agnostic.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bsa_state_t;

endpackage

// File: rtl/full_adder_one_bit.sv
// One-bit full adder.
// Ports:
//   a_i, b_i : addend bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out
module full_adder_one_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer.
// Time-shares a single full_adder_one_bit to produce a WIDTH-bit sum or
// difference, LSB first, one bit per clock. Operands are captured on an
// accepted start; result and flags are held until the next accepted start.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset
//   start     : operation request, only honoured in IDLE
//   sub       : 0 = a+b, 1 = a-b (captured with start)
//   a, b      : operands (captured with start)
//   busy      : high while bits are being processed
//   done      : one-cycle pulse when result/flags are valid
//   result    : sum or difference
//   carry_out : final carry (for subtract, 1 = no borrow)
//   overflow  : two's-complement overflow
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// RUN   | one operand bit per cycle through the shared full adder
// DONE  | one-cycle done pulse, then back to IDLE
module bit_serial_adder_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  bsa_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  logic fa_sum;
  logic fa_cy;

  full_adder_one_bit u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (cy_q),
    .s_o (fa_sum),
    .c_o (fa_cy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    co_d    = co_q;
    ov_d    = ov_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          // Subtract is a + ~b + 1: invert B and seed the carry with 1.
          b_d     = b ^ {WIDTH{sub}};
          cy_d    = sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        res_d = {fa_sum, res_q[WIDTH-1:1]};
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        cy_d  = fa_cy;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          // Signed overflow: carry into the MSB differs from carry out of it.
          ov_d    = cy_q ^ fa_cy;
          co_d    = fa_cy;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = res_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
module tb_bit_serial_adder_ctrl;

  logic clk;
  int   n_cmp;
  int   n_err;

  logic        rst8, start8, sub8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, co8, ov8;
  logic [7:0]  res8;

  logic        rst32, start32, sub32;
  logic [31:0] a32, b32;
  logic        busy32, done32, co32, ov32;
  logic [31:0] res32;

  bit_serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .carry_out(co8), .overflow(ov8)
  );

  bit_serial_adder_ctrl #(.WIDTH(32)) u32 (
    .clk(clk), .reset(rst32), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .carry_out(co32), .overflow(ov32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one 8-bit operation and observe it for 12 cycles (no comparisons).
  task automatic run8(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                      output int bc, output int dc, output int bh);
    @(negedge clk);
    start8 = 1'b1; a8 = ta; b8 = tbv; sub8 = ts;
    @(posedge clk);
    bc = 0; dc = 0; bh = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      if (busy8) bc++;
      if (done8 && dc == 0) dc = c;
      if (busy8 && done8) bh++;
    end
  endtask

  task automatic test_reset();
    rst8 = 1'b1; rst32 = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start32 = 1'b0; sub32 = 1'b0; a32 = '0; b32 = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
    n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL reset_done8: got %b expected 0", done8); end
    n_cmp++; if (res8 !== 8'h00) begin n_err++; $display("FAIL reset_result8: got %h expected 00", res8); end
    n_cmp++; if (co8 !== 1'b0) begin n_err++; $display("FAIL reset_carry8: got %b expected 0", co8); end
    n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL reset_ovf8: got %b expected 0", ov8); end
    n_cmp++; if (res32 !== 32'h0) begin n_err++; $display("FAIL reset_result32: got %h expected 0", res32); end
    n_cmp++; if (busy32 !== 1'b0) begin n_err++; $display("FAIL reset_busy32: got %b expected 0", busy32); end
    rst8 = 1'b0; rst32 = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL idle_no_start_busy8: got %b expected 0", busy8); end
  endtask

  task automatic test_add_basic();
    int bc, dc, bh;
    run8(8'h35, 8'h4A, 1'b0, bc, dc, bh);
    n_cmp++; if (res8 !== 8'h7F) begin n_err++; $display("FAIL add_35_4a_result: got %h expected 7f", res8); end
    n_cmp++; if (co8 !== 1'b0) begin n_err++; $display("FAIL add_35_4a_carry: got %b expected 0", co8); end
    n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL add_35_4a_ovf: got %b expected 0", ov8); end
    n_cmp++; if (bc !== 8) begin n_err++; $display("FAIL add_busy_cycles: got %0d expected 8", bc); end
    n_cmp++; if (dc !== 9) begin n_err++; $display("FAIL add_done_cycle: got %0d expected 9", dc); end
    n_cmp++; if (bh !== 0) begin n_err++; $display("FAIL add_busy_and_done: got %0d expected 0", bh); end
  endtask

  task automatic test_overflow();
    int bc, dc, bh;
    run8(8'h7F, 8'h01, 1'b0, bc, dc, bh);
    n_cmp++; if (res8 !== 8'h80) begin n_err++; $display("FAIL add_7f_01_result: got %h expected 80", res8); end
    n_cmp++; if (co8 !== 1'b0) begin n_err++; $display("FAIL add_7f_01_carry: got %b expected 0", co8); end
    n_cmp++; if (ov8 !== 1'b1) begin n_err++; $display("FAIL add_7f_01_ovf: got %b expected 1", ov8); end
    run8(8'hFF, 8'h01, 1'b0, bc, dc, bh);
    n_cmp++; if (res8 !== 8'h00) begin n_err++; $display("FAIL add_ff_01_result: got %h expected 00", res8); end
    n_cmp++; if (co8 !== 1'b1) begin n_err++; $display("FAIL add_ff_01_carry: got %b expected 1", co8); end
    n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL add_ff_01_ovf: got %b expected 0", ov8); end
  endtask

  task automatic test_sub();
    int bc, dc, bh;
    run8(8'h10, 8'h20, 1'b1, bc, dc, bh);
    n_cmp++; if (res8 !== 8'hF0) begin n_err++; $display("FAIL sub_10_20_result: got %h expected f0", res8); end
    n_cmp++; if (co8 !== 1'b0) begin n_err++; $display("FAIL sub_10_20_carry: got %b expected 0", co8); end
    n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL sub_10_20_ovf: got %b expected 0", ov8); end
    n_cmp++; if (dc !== 9) begin n_err++; $display("FAIL sub_done_cycle: got %0d expected 9", dc); end
    run8(8'h80, 8'h01, 1'b1, bc, dc, bh);
    n_cmp++; if (res8 !== 8'h7F) begin n_err++; $display("FAIL sub_80_01_result: got %h expected 7f", res8); end
    n_cmp++; if (co8 !== 1'b1) begin n_err++; $display("FAIL sub_80_01_carry: got %b expected 1", co8); end
    n_cmp++; if (ov8 !== 1'b1) begin n_err++; $display("FAIL sub_80_01_ovf: got %b expected 1", ov8); end
  endtask

  task automatic test_ignored_start();
    int ndone;
    ndone = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h35; b8 = 8'h4A; sub8 = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done8) ndone++;
      if (c == 1) start8 = 1'b0;
      if (c == 3) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; end
      if (c == 4) begin
        start8 = 1'b0;
        n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL ign_busy_c4: got %b expected 1", busy8); end
      end
      if (c == 9) begin
        n_cmp++; if (done8 !== 1'b1) begin n_err++; $display("FAIL ign_done_c9: got %b expected 1", done8); end
        n_cmp++; if (res8 !== 8'h7F) begin n_err++; $display("FAIL ign_result_c9: got %h expected 7f", res8); end
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; sub8 = 1'b1;
      end
      if (c == 10) begin
        n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL ign_busy_c10: got %b expected 0", busy8); end
        n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL ign_done_c10: got %b expected 0", done8); end
        n_cmp++; if (res8 !== 8'h7F) begin n_err++; $display("FAIL ign_result_c10: got %h expected 7f", res8); end
      end
      if (c == 11) begin
        n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL ign_accept_c11: got %b expected 1", busy8); end
        start8 = 1'b0;
      end
      if (c == 19) begin
        n_cmp++; if (done8 !== 1'b1) begin n_err++; $display("FAIL ign_done_c19: got %b expected 1", done8); end
        n_cmp++; if (res8 !== 8'hF0) begin n_err++; $display("FAIL ign_result_c19: got %h expected f0", res8); end
      end
    end
    n_cmp++; if (ndone !== 2) begin n_err++; $display("FAIL ign_done_count: got %0d expected 2", ndone); end
  endtask

  task automatic test_reset_mid_run();
    int ndone, bc, dc, bh;
    ndone = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h35; b8 = 8'h4A; sub8 = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      if (c == 4) begin
        rst8 = 1'b1;
        #1;
        n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy8); end
        n_cmp++; if (res8 !== 8'h00) begin n_err++; $display("FAIL midrst_result: got %h expected 00", res8); end
        n_cmp++; if (co8 !== 1'b0) begin n_err++; $display("FAIL midrst_carry: got %b expected 0", co8); end
        n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %b expected 0", ov8); end
      end
      if (c == 6) rst8 = 1'b0;
      if (done8) ndone++;
    end
    n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d expected 0", ndone); end
    n_cmp++; if (res8 !== 8'h00) begin n_err++; $display("FAIL midrst_result_after: got %h expected 00", res8); end
    run8(8'h35, 8'h4A, 1'b0, bc, dc, bh);
    n_cmp++; if (res8 !== 8'h7F) begin n_err++; $display("FAIL midrst_fresh_result: got %h expected 7f", res8); end
    n_cmp++; if (dc !== 9) begin n_err++; $display("FAIL midrst_fresh_done: got %0d expected 9", dc); end
  endtask

  task automatic test_back_to_back();
    int pulses, d1, d2, d3, bh;
    pulses = 0; d1 = 0; d2 = 0; d3 = 0; bh = 0;
    @(negedge clk);
    start32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h1; sub32 = 1'b0;
    for (int c = 1; c <= 120 && pulses < 3; c++) begin
      @(negedge clk);
      if (busy32 && done32) bh++;
      if (done32) begin
        pulses++;
        if (pulses == 1) d1 = c;
        if (pulses == 2) d2 = c;
        if (pulses == 3) begin d3 = c; start32 = 1'b0; end
        n_cmp++; if (res32 !== 32'h0) begin n_err++; $display("FAIL b2b_result_%0d: got %h expected 0", pulses, res32); end
        n_cmp++; if (co32 !== 1'b1) begin n_err++; $display("FAIL b2b_carry_%0d: got %b expected 1", pulses, co32); end
        n_cmp++; if (ov32 !== 1'b0) begin n_err++; $display("FAIL b2b_ovf_%0d: got %b expected 0", pulses, ov32); end
      end
    end
    start32 = 1'b0;
    n_cmp++; if (pulses !== 3) begin n_err++; $display("FAIL b2b_pulse_count: got %0d expected 3", pulses); end
    n_cmp++; if (d2 - d1 !== 34) begin n_err++; $display("FAIL b2b_spacing_1: got %0d expected 34", d2 - d1); end
    n_cmp++; if (d3 - d2 !== 34) begin n_err++; $display("FAIL b2b_spacing_2: got %0d expected 34", d3 - d2); end
    n_cmp++; if (bh !== 0) begin n_err++; $display("FAIL b2b_busy_and_done: got %0d expected 0", bh); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_add_basic();
    test_overflow();
    test_sub();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
